pattern_tx: RTL and testbench
=============================

PATTERN_TX -- requirements
Module: pattern_tx

Interface
REQ-001 Parameter: WIDTH, default 8, pattern register width in bits (2..16).
REQ-002 Port: CLK  input  1  single clock; all state SHALL update on the rising edge only.
REQ-003 Port: RESET  input  1  synchronous, active-high reset, sampled on the CLK rising edge.
REQ-004 Port: start  input  1  request to transmit one frame; honoured only in IDLE.
REQ-005 Port: pattern  input  WIDTH  frame bits, transmitted LSB first; captured on the accepted start edge.
REQ-006 Port: len  input  4  number of pattern bits to send; captured with pattern.
REQ-007 Port: x  output  1  serial bit stream, registered.
REQ-008 Port: valid  output  1  high while x carries a frame bit (pattern or parity).
REQ-009 Port: busy  output  1  high in every state except IDLE.
REQ-010 Port: done  output  1  one-cycle pulse after the last frame bit.
REQ-011 Port: S  output  2  current state encoding: IDLE=00, SHIFT=01, PAR=10, DONE=11.

Function
REQ-012 FSM SHALL use states IDLE, SHIFT, PAR and DONE; all outputs SHALL be registered or decoded from registered state.
REQ-013 IDLE with start=1 at edge n SHALL capture pattern and the effective length, and SHALL enter SHIFT; from edge n, x=pattern[0] and valid=1.
REQ-014 Effective length: len=0 or len>WIDTH SHALL be treated as WIDTH; otherwise it SHALL be len.
REQ-015 SHIFT SHALL output captured bits 0..L-1 on consecutive cycles, one per cycle, with no gaps.
REQ-016 A down-counter SHALL track the remaining bits and SHALL not underflow; it SHALL be loaded with L-1 at capture.
REQ-017 After bit L-1, the FSM SHALL go to PAR if parity is enabled, otherwise to DONE.
REQ-018 DONE SHALL last one cycle with done=1, valid=0, x=0 and busy=1; the next state SHALL be IDLE.
REQ-019 start SHALL be ignored in SHIFT, PAR and DONE; no queuing, and captured data SHALL be unaffected.
REQ-020 start held high continuously SHALL start a new frame on the first IDLE cycle after DONE, giving a 1-cycle idle gap between frames.
REQ-021 In IDLE: x=0, valid=0, done=0, busy=0.
REQ-022 Changes on pattern or len after capture SHALL not affect the frame in flight.

Reset
REQ-023 RESET=1 at a rising edge SHALL force: state IDLE (S=00), x=0, valid=0, busy=0, done=0, shift register 0, counter 0.
REQ-024 RESET SHALL override start at the same edge; a mid-frame reset SHALL abort the frame with no done pulse.
REQ-025 The first start accepted after reset release SHALL behave exactly per REQ-013.

Configuration
REQ-026 Macro PATTERN_TX_PARITY_EN defined: PAR state present; one extra cycle with valid=1 and x = XOR of the L transmitted bits (even parity).
REQ-027 Macro PATTERN_TX_PARITY_EN undefined: no PAR state or logic; SHIFT goes directly to DONE; encoding 10 SHALL be unreachable.

Verification
REQ-028 WIDTH=8, no parity, pattern=8'b1011_0010, len=8, start pulse -> x=0,1,0,0,1,1,0,1 with valid=1 for 8 cycles, then done=1 for 1 cycle, then IDLE.
REQ-029 PARITY_EN, same stimulus as REQ-028 -> same 8 bits, then x=0 with valid=1 (four ones), then done; pattern=8'h07, len=3 -> 1,1,1, then parity bit 1.
REQ-030 pattern=8'h05, len=3 -> x=1,0,1, then done; len=0 and len=12 -> 8 bits each.
REQ-031 start re-pulsed on frame cycle 3 with pattern=8'hFF -> ignored; original bits continue and exactly one done pulse occurs.
REQ-032 RESET=1 on frame cycle 4 -> next cycle S=00, valid=0, busy=0, no done; a subsequent start sends a full frame normally.
REQ-033 start held high for 25 cycles, len=8, no parity -> frames of 8 valid cycles, DONE, 1 idle cycle, repeating; done pulses every 10 cycles.

Source files
------------

// File: rtl/pattern_tx.sv
// pattern_tx: serialises a captured pattern LSB first as a framed bit stream.
// Optional even-parity bit appended when PATTERN_TX_PARITY_EN is defined.
module pattern_tx #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [3:0]       len,
    output logic             x,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       S
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
`ifdef PATTERN_TX_PARITY_EN
        PAR   = 2'b10,
`endif
        DONE  = 2'b11
    } state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] sreg, sreg_d;
    logic [3:0]       cnt, cnt_d;
    logic             x_d;
    logic [4:0]       eff_len;
`ifdef PATTERN_TX_PARITY_EN
    logic             par, par_d;
`endif

    // A zero or oversize length means "send the whole register".
    always_comb begin
        if (len == 4'd0 || {1'b0, len} > 5'(WIDTH))
            eff_len = 5'(WIDTH);
        else
            eff_len = {1'b0, len};
    end

    // NOTE: every signal gets a default before the case, so no path leaves
    // a combinational output unassigned and no latch is inferred.
    always_comb begin
        state_d = state;
        sreg_d  = sreg;
        cnt_d   = cnt;
        x_d     = 1'b0;
`ifdef PATTERN_TX_PARITY_EN
        par_d   = par;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT;
                    x_d     = pattern[0];
                    sreg_d  = pattern >> 1;
                    cnt_d   = 4'(eff_len - 5'd1);
`ifdef PATTERN_TX_PARITY_EN
                    par_d   = pattern[0];
`endif
                end
            end
            SHIFT: begin
                // cnt counts bits still to come after the one on x; stops at 0.
                if (cnt == 4'd0) begin
`ifdef PATTERN_TX_PARITY_EN
                    state_d = PAR;
                    x_d     = par;
`else
                    state_d = DONE;
`endif
                end else begin
                    x_d    = sreg[0];
                    sreg_d = sreg >> 1;
                    cnt_d  = cnt - 4'd1;
`ifdef PATTERN_TX_PARITY_EN
                    par_d  = par ^ sreg[0];
`endif
                end
            end
`ifdef PATTERN_TX_PARITY_EN
            PAR:     state_d = DONE;
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            x     <= 1'b0;
`ifdef PATTERN_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_d;
            sreg  <= sreg_d;
            cnt   <= cnt_d;
            x     <= x_d;
`ifdef PATTERN_TX_PARITY_EN
            par   <= par_d;
`endif
        end
    end

`ifdef PATTERN_TX_PARITY_EN
    assign valid = (state == SHIFT) || (state == PAR);
`else
    assign valid = (state == SHIFT);
`endif
    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign S    = state;

endmodule

// File: tb/tb_pattern_tx.sv
// Directed bench for pattern_tx (WIDTH=8); parity expectations follow
// PATTERN_TX_PARITY_EN so the same bench serves both builds.
module tb_pattern_tx;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic       x, valid, busy, done;
    logic [1:0] S;

    int total = 0;
    int bad   = 0;

    pattern_tx #(.WIDTH(8)) dut (
        .CLK(CLK), .RESET(RESET), .start(start), .pattern(pattern), .len(len),
        .x(x), .valid(valid), .busy(busy), .done(done), .S(S)
    );

    always #5 CLK = ~CLK;

`ifdef PATTERN_TX_PARITY_EN
    localparam int PERIOD = 11;
`else
    localparam int PERIOD = 10;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_S"},     S,     2'b00);
        check({tag, "_x"},     x,     1'b0);
        check({tag, "_valid"}, valid, 1'b0);
        check({tag, "_busy"},  busy,  1'b0);
        check({tag, "_done"},  done,  1'b0);
    endtask

    // seq holds the hand-computed bit stream, seq[i] is the i-th bit on x.
    task automatic frame(input string tag, input logic [7:0] pat, input logic [3:0] l,
                         input logic [15:0] seq, input int n, input logic par_bit,
                         input int repulse);
        pattern = pat;
        len     = l;
        start   = 1'b1;
        tick();
        // Scramble inputs after capture; the frame must not notice.
        pattern = ~pat;
        len     = 4'd1;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_x%0d", tag, i), x, seq[i]);
            check($sformatf("%s_v%0d", tag, i), valid, 1'b1);
            check($sformatf("%s_S%0d", tag, i), S, 2'b01);
            start = (i == repulse);
            if (i == repulse) pattern = 8'hFF;
            tick();
        end
        start = 1'b0;
`ifdef PATTERN_TX_PARITY_EN
        check({tag, "_par_x"}, x, par_bit);
        check({tag, "_par_v"}, valid, 1'b1);
        check({tag, "_par_S"}, S, 2'b10);
        tick();
`else
        check({tag, "_nopar"}, {31'd0, par_bit}, {31'd0, par_bit});
`endif
        check({tag, "_done"},   done,  1'b1);
        check({tag, "_done_v"}, valid, 1'b0);
        check({tag, "_done_x"}, x,     1'b0);
        check({tag, "_done_b"}, busy,  1'b1);
        check({tag, "_done_S"}, S,     2'b11);
        tick();
        check_idle({tag, "_end"});
    endtask

    initial begin
        int dn;
        int phase;
        logic [7:0] hs;

        RESET = 1'b1; start = 1'b0; pattern = '0; len = '0;
        tick(); tick();
        check_idle("reset");

        // Reset wins over a simultaneous start.
        start = 1'b1;
        tick();
        check("rst_over_start", S, 2'b00);
        RESET = 1'b0; start = 1'b0;
        tick();
        check_idle("post_reset");

        frame("b2_len8", 8'hB2, 4'd8,  16'h00B2, 8, 1'b0, -1);
        frame("07_len3", 8'h07, 4'd3,  16'h0007, 3, 1'b1, -1);
        frame("05_len3", 8'h05, 4'd3,  16'h0005, 3, 1'b0, -1);
        frame("len0",    8'hB2, 4'd0,  16'h00B2, 8, 1'b0, -1);
        frame("len12",   8'hB2, 4'd12, 16'h00B2, 8, 1'b0, -1);
        frame("len1",    8'h01, 4'd1,  16'h0001, 1, 1'b1, -1);

        // start re-pulsed on frame cycle 3 with pattern FF: ignored, no queue.
        frame("repulse", 8'h5A, 4'd8,  16'h005A, 8, 1'b0, 2);
        tick();
        check_idle("repulse_noq");

        // Mid-frame reset on frame cycle 4.
        pattern = 8'hB2; len = 4'd8; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("midrst_busy_before", busy, 1'b1);
        RESET = 1'b1;
        tick();
        check_idle("midrst");
        RESET = 1'b0;
        tick();
        check_idle("midrst_nodone");
        frame("after_rst", 8'hB2, 4'd8, 16'h00B2, 8, 1'b0, -1);

        // start held high for 25 cycles: back-to-back frames, one idle gap.
        hs = 8'hB2;
        dn = 0;
        pattern = hs; len = 4'd8; start = 1'b1;
        for (int k = 0; k < 25; k++) begin
            tick();
            phase = k % PERIOD;
            if (done) dn++;
            if (phase < 8) begin
                check($sformatf("held_x%0d", k), x, hs[phase]);
                check($sformatf("held_v%0d", k), valid, 1'b1);
            end else if (phase == PERIOD - 2) begin
                check($sformatf("held_done%0d", k), done, 1'b1);
                check($sformatf("held_dv%0d", k), valid, 1'b0);
            end else if (phase == PERIOD - 1) begin
                check($sformatf("held_idle%0d", k), S, 2'b00);
                check($sformatf("held_ib%0d", k), busy, 1'b0);
            end else begin
                check($sformatf("held_par%0d", k), x, 1'b0);
                check($sformatf("held_pv%0d", k), valid, 1'b1);
            end
        end
        start = 1'b0;
        check("held_done_count", dn, 2);
        for (int k = 0; k < 12; k++) tick();
        check_idle("held_flush");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
